// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampled serial receive framer.
// Synchronises the idle-high serial line, finds the start bit, samples each
// bit at its centre (LSB first), assembles DATA_BITS into a word and checks
// the stop bit. Good frames update rx_data with a one-cycle rx_valid pulse.
// Build option: define UART_RX_PARITY_EN to insert a parity bit (even when
// PARITY_ODD=0, odd when PARITY_ODD=1) between the data and the stop bit.
module uart_rx_framer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data,
    output logic                 en,
    output logic                 busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_framer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 data_p0;
    logic                 data_p1;
    logic                 data_s;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;
    logic                 bit_tick;

`ifdef UART_RX_PARITY_EN
    logic                 par_bad;

    // Expected parity bit for the assembled word.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] w);
        return (^w) ^ (PARITY_ODD != 0);
    endfunction
`endif

    assign data_s   = data_p1;
    assign bit_tick = (bit_cnt == CNT_LAST);

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p0 <= 1'b1;
            data_p1 <= 1'b1;
        end else begin
            data_p0 <= data;
            data_p1 <= data_p0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_next = state;
        en         = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (!data_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_cnt == CNT_HALF) begin
                    state_next = data_s ? IDLE : DATA;
                end
            end
            DATA: begin
                en = 1'b1;
                if (bit_tick && idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                en = 1'b1;
                if (bit_tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_next = data_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (data_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Oversample counter; the start-detect cycle already counts as the first
    // cycle of the start bit, so START is entered with the count at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (state_next != state) begin
            bit_cnt <= (state == IDLE) ? CNT_ONE : '0;
        end else if (state == IDLE || bit_tick) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
        end
    end

    // Bit assembly, parity capture and end-of-frame result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            shift      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (state == START) begin
                idx <= '0;
`ifdef UART_RX_PARITY_EN
                par_bad <= 1'b0;
`endif
            end
            if (state == DATA && bit_tick) begin
                for (int i = 0; i < DATA_BITS; i++) begin
                    if (idx == IDX_W'(i)) begin
                        shift[i] <= data_s;
                    end
                end
                idx <= idx + IDX_ONE;
            end
`ifdef UART_RX_PARITY_EN
            if (state == PARITY && bit_tick) begin
                par_bad <= (data_s != parity_bit(shift));
            end
`endif
            if (state == STOP && bit_tick) begin
                if (!data_s) begin
                    frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                end else if (par_bad) begin
                    parity_err <= 1'b1;
`endif
                end else begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed testbench for uart_rx_framer (DATA_BITS=8, OVERSAMPLE=16).
// Frames are driven on the pin; t0 is the first cycle the synchronised line
// is low, i.e. two cycles after the pin is driven low.
`timescale 1ns/1ps
module tb_uart_rx_framer;

    localparam int DATA_BITS = 8;
    localparam int OS        = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int VALID_OFS = 152 + 16 * PAR;
    localparam int EN_CYC    = 128 + 16 * PAR;
    localparam int FRAME_CYC = 160 + 16 * PAR;

    logic       clk = 1'b0;
    logic       rst;
    logic       data;
    logic       en;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int n_valid = 0, n_ferr = 0, n_perr = 0, n_en = 0, n_multi = 0;
    int last_valid = -1, prev_valid = -1, last_ferr = -1, last_perr = -1, busy_fall = -1;
    logic busy_q = 1'b0;

    uart_rx_framer #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OS),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .en        (en),
        .busy      (busy),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_valid    <= n_valid + 1;
            prev_valid <= last_valid;
            last_valid <= cyc;
        end
        if (frame_err === 1'b1) begin
            n_ferr    <= n_ferr + 1;
            last_ferr <= cyc;
        end
        if (parity_err === 1'b1) begin
            n_perr    <= n_perr + 1;
            last_perr <= cyc;
        end
        if (en === 1'b1) n_en <= n_en + 1;
        if (((rx_valid === 1'b1) && (frame_err === 1'b1)) ||
            ((rx_valid === 1'b1) && (parity_err === 1'b1)) ||
            ((frame_err === 1'b1) && (parity_err === 1'b1))) n_multi <= n_multi + 1;
        if (busy_q === 1'b1 && busy === 1'b0) busy_fall <= cyc;
        busy_q <= busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        data = b;
        repeat (OS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b,
                              output int t0);
        t0 = cyc + 2;
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(b[i]);
        if (PAR != 0) drive_bit(par_b);
        drive_bit(stop_b);
    endtask

    // Run-time bound.
    initial begin
        #200us;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t0b, v0, f0, p0, e0, r;
        rst  = 1'b1;
        data = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_rx_data", 32'(rx_data), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_en", 32'(en), 32'h0);
        chk("reset_pulses", {29'b0, rx_valid, frame_err, parity_err}, 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 1: 0xA5, clean frame
        v0 = n_valid; f0 = n_ferr; p0 = n_perr; e0 = n_en;
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        chk("t1_valid_count", 32'(n_valid - v0), 32'd1);
        chk("t1_valid_time", 32'(last_valid - t0), 32'(VALID_OFS));
        chk("t1_rx_data", 32'(rx_data), 32'hA5);
        chk("t1_en_cycles", 32'(n_en - e0), 32'(EN_CYC));
        chk("t1_no_errors", 32'((n_ferr - f0) + (n_perr - p0)), 32'd0);

        // 2: three-cycle glitch
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        r  = cyc;
        data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        data = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("t2_busy_fall", 32'(busy_fall - (r + 2)), 32'd8);
        chk("t2_no_pulses", 32'((n_valid - v0) + (n_ferr - f0) + (n_perr - p0)), 32'd0);
        chk("t2_rx_data", 32'(rx_data), 32'hA5);

        // 3: 0x5A with low stop bit, line held low (break)
        v0 = n_valid; f0 = n_ferr; p0 = n_perr; e0 = n_en;
        send_frame(8'h5A, 1'b0, 1'b0, t0);
        repeat (400) @(posedge clk);
        #1;
        chk("t3_ferr_count", 32'(n_ferr - f0), 32'd1);
        chk("t3_ferr_time", 32'(last_ferr - t0), 32'(VALID_OFS));
        chk("t3_busy_in_break", 32'(busy), 32'd1);
        chk("t3_rx_data_held", 32'(rx_data), 32'hA5);
        r = cyc;
        data = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t3_busy_fall", 32'(busy_fall - r), 32'd3);
        chk("t3_no_valid", 32'(n_valid - v0), 32'd0);
        chk("t3_no_perr", 32'(n_perr - p0), 32'd0);
        chk("t3_single_frame_en", 32'(n_en - e0), 32'(EN_CYC));

        // 4: back-to-back 0x55 then 0xAA
        repeat (5) @(posedge clk);
        #1;
        v0 = n_valid;
        send_frame(8'h55, 1'b1, 1'b0, t0);
        chk("t4_first_time", 32'(last_valid - t0), 32'(VALID_OFS));
        chk("t4_first_data", 32'(rx_data), 32'h55);
        send_frame(8'hAA, 1'b1, 1'b0, t0b);
        chk("t4_spacing", 32'(last_valid - prev_valid), 32'(FRAME_CYC));
        chk("t4_second_data", 32'(rx_data), 32'hAA);
        chk("t4_valid_count", 32'(n_valid - v0), 32'd2);

        // 5: reset at t0+70 mid-frame, then 0x3C
        repeat (5) @(posedge clk);
        #1;
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        r  = cyc;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        data = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t5_cycle_at_reset", 32'(cyc - (r + 2)), 32'd70);
        chk("t5_en_before_rst", 32'(en), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_outputs_after_rst", {25'b0, en, busy, rx_valid, frame_err, parity_err, 2'b0}, 32'h0);
        chk("t5_rx_data_after_rst", 32'(rx_data), 32'h0);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("t5_no_pulses", 32'((n_valid - v0) + (n_ferr - f0) + (n_perr - p0)), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, t0);
        chk("t5_valid_time", 32'(last_valid - t0), 32'(VALID_OFS));
        chk("t5_rx_data", 32'(rx_data), 32'h3C);

`ifdef UART_RX_PARITY_EN
        // 6: even parity, 0x03 with good then bad parity bit
        repeat (5) @(posedge clk);
        #1;
        send_frame(8'h03, 1'b1, 1'b0, t0);
        chk("t6_valid_time", 32'(last_valid - t0), 32'd168);
        chk("t6_rx_data", 32'(rx_data), 32'h03);
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        send_frame(8'h03, 1'b1, 1'b1, t0);
        chk("t6_perr_count", 32'(n_perr - p0), 32'd1);
        chk("t6_perr_time", 32'(last_perr - t0), 32'd168);
        chk("t6_no_valid_ferr", 32'((n_valid - v0) + (n_ferr - f0)), 32'd0);
        chk("t6_rx_data_held", 32'(rx_data), 32'h03);
`endif

        chk("one_pulse_per_cycle", 32'(n_multi), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
